// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding
// and the hard-wired zero register number.
package pipe_ctl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Bundle between the hazard controller (master) and the pipeline datapath (slave).
// dmem_req/dmem_hit: a MEM-stage data access is presented with dmem_req and is
// complete only in a cycle where dmem_hit is also high; until then the core freezes.
interface pipe_hazard_ctl_if
  import pipe_ctl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             dmem_req;
  logic             dmem_hit;
  logic             imem_hit;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             branch_taken;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_we;
  logic             idex_bubble;
  logic             exmem_we;
  logic             exmem_flush;
  logic             memwb_we;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  state_t           state;

  modport master (
    input  dmem_req, dmem_hit, imem_hit, idex_memread, idex_rt,
           ifid_rs, ifid_rt, ifid_uses_rt, branch_taken,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
           exmem_we, exmem_flush, memwb_we, mem_err, stall_cycles, state
  );

  modport slave (
    output dmem_req, dmem_hit, imem_hit, idex_memread, idex_rt,
           ifid_rs, ifid_rt, ifid_uses_rt, branch_taken,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
           exmem_we, exmem_flush, memwb_we, mem_err, stall_cycles, state
  );

endinterface

// File: rtl/pipe_hazard_ctl_hazard_detect.sv
// Load-use detector: the load in EX writes a register the instruction in ID
// reads. Writes to $zero never create a dependency.
module hazard_detect
  import pipe_ctl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  output logic       load_use
);

  always_comb begin
    load_use = idex_memread && (idex_rt != REG_ZERO) &&
               ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline sequencing controller: freezes on D-cache misses (with timeout to a
// sticky error state), stalls on load-use, squashes on taken branches and
// inserts IF bubbles on I-cache misses. Counts stalled-PC cycles.
module pipe_hazard_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
)(
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctl_if.master bus
);

  localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q;
  logic               err_q, err_d;

  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_bubble, exmem_flush;
  logic load_use, dmiss, apply_rules;

  hazard_detect u_hazard_detect (
    .idex_memread (bus.idex_memread),
    .idex_rt      (bus.idex_rt),
    .ifid_rs      (bus.ifid_rs),
    .ifid_rt      (bus.ifid_rt),
    .ifid_uses_rt (bus.ifid_uses_rt),
    .load_use     (load_use)
  );

  assign dmiss = bus.dmem_req && !bus.dmem_hit;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    apply_rules = 1'b0;
    state_d     = state_q;
    wait_d      = wait_q;
    err_d       = err_q;

    case (state_q)
      RUN: begin
        if (dmiss) begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
          state_d = DMISS;
          wait_d  = WAIT_W'(1);
        end else begin
          apply_rules = 1'b1;
        end
      end
      DMISS: begin
        if (!bus.dmem_hit) begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end else begin
          // Hazards that arrived while frozen take effect on the exit cycle.
          apply_rules = 1'b1;
          state_d     = RUN;
          wait_d      = '0;
        end
      end
      default: begin
        {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
        state_d = (state_q == ERR) ? ERR : RUN;
      end
    endcase

    if (apply_rules) begin
      if (bus.branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end else if (!bus.imem_hit) begin
        pc_we      = 1'b0;
        ifid_flush = 1'b1;
      end
    end

    if (rst) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
      ifid_flush  = 1'b0;
      exmem_flush = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (!pc_we && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.ifid_we      = ifid_we;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_we      = idex_we;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_we     = exmem_we;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.memwb_we     = memwb_we;
  assign bus.mem_err      = err_q;
  assign bus.stall_cycles = stall_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl with a short timeout (MAX_WAIT=4) and a
// 4-bit stall counter so that timeout and saturation are reached quickly.
module tb_pipe_hazard_ctl;
  import pipe_ctl_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipe_hazard_ctl_if #(.CNT_W(4)) bus ();

  pipe_hazard_ctl #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [4:0] we_v = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we};
  wire [2:0] fl_v = {bus.ifid_flush, bus.idex_bubble, bus.exmem_flush};
  wire [1:0] st_v = bus.state;
  wire [3:0] sc_v = bus.stall_cycles;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dmem_req     = 1'b0;
    bus.dmem_hit     = 1'b0;
    bus.imem_hit     = 1'b1;
    bus.idex_memread = 1'b0;
    bus.idex_rt      = 5'd0;
    bus.ifid_rs      = 5'd0;
    bus.ifid_rt      = 5'd0;
    bus.ifid_uses_rt = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    total++; if (we_v !== 5'b00000) begin bad++; $display("FAIL reset_we got=%b want=%b", we_v, 5'b00000); end
    total++; if (fl_v !== 3'b010) begin bad++; $display("FAIL reset_flush got=%b want=%b", fl_v, 3'b010); end
    total++; if (sc_v !== 4'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", sc_v); end
    total++; if (st_v !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st_v); end
    total++; if (bus.mem_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.mem_err); end
    rst = 1'b0;
    #1;
    total++; if (we_v !== 5'b11111) begin bad++; $display("FAIL release_we got=%b want=%b", we_v, 5'b11111); end
    total++; if (fl_v !== 3'b000) begin bad++; $display("FAIL release_flush got=%b want=%b", fl_v, 3'b000); end
    step();
    total++; if (sc_v !== 4'd0) begin bad++; $display("FAIL release_stall got=%0d want=0", sc_v); end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
    #1;
    total++; if (we_v !== 5'b00111) begin bad++; $display("FAIL lu_rs_we got=%b want=%b", we_v, 5'b00111); end
    total++; if (fl_v !== 3'b010) begin bad++; $display("FAIL lu_rs_flush got=%b want=%b", fl_v, 3'b010); end
    step();
    total++; if (sc_v !== 4'd1) begin bad++; $display("FAIL lu_rs_stall got=%0d want=1", sc_v); end
    bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
    #1;
    total++; if (we_v !== 5'b11111) begin bad++; $display("FAIL lu_zero_we got=%b want=%b", we_v, 5'b11111); end
    total++; if (fl_v !== 3'b000) begin bad++; $display("FAIL lu_zero_flush got=%b want=%b", fl_v, 3'b000); end
    step();
    bus.idex_rt = 5'd7; bus.ifid_rt = 5'd7; bus.ifid_rs = 5'd3; bus.ifid_uses_rt = 1'b1;
    #1;
    total++; if (we_v !== 5'b00111) begin bad++; $display("FAIL lu_rt_we got=%b want=%b", we_v, 5'b00111); end
    step();
    bus.ifid_uses_rt = 1'b0;
    #1;
    total++; if (we_v !== 5'b11111) begin bad++; $display("FAIL lu_rt_unused_we got=%b want=%b", we_v, 5'b11111); end
    step();
    total++; if (sc_v !== 4'd2) begin bad++; $display("FAIL lu_total_stall got=%0d want=2", sc_v); end
    idle();
  endtask

  task automatic test_dmiss();
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_hit = 1'b0;
    #1;
    total++; if (we_v !== 5'b00000) begin bad++; $display("FAIL dm_c1_we got=%b want=%b", we_v, 5'b00000); end
    total++; if (st_v !== 2'd0) begin bad++; $display("FAIL dm_c1_state got=%0d want=0", st_v); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (st_v !== 2'd1) begin bad++; $display("FAIL dm_freeze_state got=%0d want=1", st_v); end
      total++; if (we_v !== 5'b00000) begin bad++; $display("FAIL dm_freeze_we got=%b want=%b", we_v, 5'b00000); end
    end
    step();
    bus.dmem_hit = 1'b1;
    #1;
    total++; if (we_v !== 5'b11111) begin bad++; $display("FAIL dm_hit_we got=%b want=%b", we_v, 5'b11111); end
    total++; if (fl_v !== 3'b000) begin bad++; $display("FAIL dm_hit_flush got=%b want=%b", fl_v, 3'b000); end
    step();
    idle();
    total++; if (st_v !== 2'd0) begin bad++; $display("FAIL dm_exit_state got=%0d want=0", st_v); end
    total++; if (sc_v !== 4'd3) begin bad++; $display("FAIL dm_stall got=%0d want=3", sc_v); end
    total++; if (bus.mem_err !== 1'b0) begin bad++; $display("FAIL dm_err got=%b want=0", bus.mem_err); end
  endtask

  task automatic test_miss_branch();
    do_reset();
    bus.branch_taken = 1'b1; bus.dmem_req = 1'b1; bus.dmem_hit = 1'b0;
    #1;
    total++; if (we_v !== 5'b00000) begin bad++; $display("FAIL mb_c1_we got=%b want=%b", we_v, 5'b00000); end
    total++; if (fl_v !== 3'b000) begin bad++; $display("FAIL mb_c1_flush got=%b want=%b", fl_v, 3'b000); end
    step();
    total++; if (we_v !== 5'b00000) begin bad++; $display("FAIL mb_c2_we got=%b want=%b", we_v, 5'b00000); end
    step();
    bus.dmem_hit = 1'b1;
    #1;
    total++; if (we_v !== 5'b11111) begin bad++; $display("FAIL mb_exit_we got=%b want=%b", we_v, 5'b11111); end
    total++; if (fl_v !== 3'b111) begin bad++; $display("FAIL mb_exit_flush got=%b want=%b", fl_v, 3'b111); end
    step();
    idle();
    total++; if (st_v !== 2'd0) begin bad++; $display("FAIL mb_exit_state got=%0d want=0", st_v); end
    do_reset();
    bus.imem_hit = 1'b0; bus.dmem_req = 1'b1; bus.dmem_hit = 1'b0;
    step();
    bus.dmem_hit = 1'b1;
    #1;
    total++; if (we_v !== 5'b01111) begin bad++; $display("FAIL mi_exit_we got=%b want=%b", we_v, 5'b01111); end
    total++; if (fl_v !== 3'b100) begin bad++; $display("FAIL mi_exit_flush got=%b want=%b", fl_v, 3'b100); end
    step();
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (st_v !== 2'd1) begin bad++; $display("FAIL to_wait_state got=%0d want=1", st_v); end
      total++; if (bus.mem_err !== 1'b0) begin bad++; $display("FAIL to_wait_err got=%b want=0", bus.mem_err); end
    end
    step();
    total++; if (st_v !== 2'd2) begin bad++; $display("FAIL to_err_state got=%0d want=2", st_v); end
    total++; if (bus.mem_err !== 1'b1) begin bad++; $display("FAIL to_err_flag got=%b want=1", bus.mem_err); end
    bus.dmem_hit = 1'b1; bus.branch_taken = 1'b1;
    #1;
    total++; if (we_v !== 5'b00000) begin bad++; $display("FAIL to_err_we got=%b want=%b", we_v, 5'b00000); end
    total++; if (fl_v !== 3'b000) begin bad++; $display("FAIL to_err_flush got=%b want=%b", fl_v, 3'b000); end
    step();
    step();
    total++; if (st_v !== 2'd2) begin bad++; $display("FAIL to_hold_state got=%0d want=2", st_v); end
    total++; if (bus.mem_err !== 1'b1) begin bad++; $display("FAIL to_hold_err got=%b want=1", bus.mem_err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    total++; if (st_v !== 2'd0) begin bad++; $display("FAIL to_rst_state got=%0d want=0", st_v); end
    total++; if (bus.mem_err !== 1'b0) begin bad++; $display("FAIL to_rst_err got=%b want=0", bus.mem_err); end
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_hit = 1'b0;
    step();
    total++; if (st_v !== 2'd1) begin bad++; $display("FAIL rm_state got=%0d want=1", st_v); end
    rst = 1'b1;
    #1;
    total++; if (fl_v !== 3'b010) begin bad++; $display("FAIL rm_rst_flush got=%b want=%b", fl_v, 3'b010); end
    step();
    total++; if (st_v !== 2'd0) begin bad++; $display("FAIL rm_after_state got=%0d want=0", st_v); end
    rst = 1'b0;
    idle();
    #1;
    total++; if (we_v !== 5'b11111) begin bad++; $display("FAIL rm_after_we got=%b want=%b", we_v, 5'b11111); end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.imem_hit = 1'b0;
    #1;
    total++; if (we_v !== 5'b01111) begin bad++; $display("FAIL im_we got=%b want=%b", we_v, 5'b01111); end
    total++; if (fl_v !== 3'b100) begin bad++; $display("FAIL im_flush got=%b want=%b", fl_v, 3'b100); end
    repeat (14) step();
    total++; if (sc_v !== 4'd14) begin bad++; $display("FAIL sat_14 got=%0d want=14", sc_v); end
    repeat (6) step();
    total++; if (sc_v !== 4'd15) begin bad++; $display("FAIL sat_20 got=%0d want=15", sc_v); end
    idle();
    step();
    total++; if (sc_v !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", sc_v); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.branch_taken = 1'b1; bus.idex_memread = 1'b1; bus.idex_rt = 5'd9;
    bus.ifid_rs = 5'd9; bus.imem_hit = 1'b0;
    #1;
    total++; if (we_v !== 5'b11111) begin bad++; $display("FAIL pr_br_we got=%b want=%b", we_v, 5'b11111); end
    total++; if (fl_v !== 3'b111) begin bad++; $display("FAIL pr_br_flush got=%b want=%b", fl_v, 3'b111); end
    bus.branch_taken = 1'b0;
    #1;
    total++; if (we_v !== 5'b00111) begin bad++; $display("FAIL pr_lu_we got=%b want=%b", we_v, 5'b00111); end
    total++; if (fl_v !== 3'b010) begin bad++; $display("FAIL pr_lu_flush got=%b want=%b", fl_v, 3'b010); end
    step();
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_dmiss();
    test_miss_branch();
    test_timeout();
    test_reset_mid_miss();
    test_saturation();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates write-enables, flush and bubble controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- idex_we drives the ID_EX load enable (its data_hit input); idex_bubble zeroes the wb/m/ex control fields entering ID_EX.
- Handles data-cache miss freeze (FSM with timeout), load-use stalls, branch flush and I-cache miss bubbles; keeps a saturating stall counter.

Parameters:
- MAX_WAIT, 64, cycles allowed in DMISS before declaring a memory error (>=2).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- dmem_req  in  1  MEM stage instruction accesses data memory this cycle.
- dmem_hit  in  1  data access completes this cycle.
- imem_hit  in  1  instruction fetch completes this cycle.
- idex_memread  in  1  instruction in EX is a load (ID_EX m_ctl read bit).
- idex_rt  in  5  destination register of the load in EX.
- ifid_rs  in  5  rs field of the instruction in ID.
- ifid_rt  in  5  rt field of the instruction in ID.
- ifid_uses_rt  in  1  instruction in ID reads rt as a source.
- branch_taken  in  1  branch resolved taken in MEM this cycle.
- pc_we  out  1  PC load enable.
- ifid_we  out  1  IF_ID load enable.
- ifid_flush  out  1  IF_ID loads a NOP instead of fetched data.
- idex_we  out  1  ID_EX load enable.
- idex_bubble  out  1  ID_EX control fields forced to 0.
- exmem_we  out  1  EX_MEM load enable.
- exmem_flush  out  1  EX_MEM control fields forced to 0.
- memwb_we  out  1  MEM_WB load enable.
- mem_err  out  1  sticky: data access exceeded MAX_WAIT.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0.
- state  out  2  FSM state (debug).

Behaviour:
- States: RUN=0, DMISS=1, ERR=2. Registered: state, wait_cnt (log2 MAX_WAIT bits), stall_cycles, mem_err. All control outputs are combinational from state and inputs (same-cycle effect).
- Reset (rst=1 at posedge): state=RUN, wait_cnt=0, stall_cycles=0, mem_err=0.
- While rst=1: all *_we=0, ifid_flush=0, exmem_flush=0, idex_bubble=1.
- Default outputs: all *_we=1, all flush/bubble=0.
- RUN decision, first match wins:
  1. dmiss = dmem_req & !dmem_hit: all *_we=0; next state=DMISS, wait_cnt=1.
  2. branch_taken: all *_we=1, ifid_flush=1, idex_bubble=1, exmem_flush=1 (squash the 3 younger instructions).
  3. load-use = idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)): pc_we=0, ifid_we=0, idex_bubble=1; others 1. One-cycle stall; re-evaluated next cycle (normally clears).
  4. !imem_hit: pc_we=0, ifid_we=1 with ifid_flush=1; others 1.
- Branch beats load-use and I-miss: the stalled instructions are squashed anyway.
- DMISS, dmem_hit=0: all *_we=0; wait_cnt++. If wait_cnt==MAX_WAIT-1, next state=ERR and mem_err=1.
- DMISS, dmem_hit=1: outputs exactly as RUN rules 2-4 with dmiss treated as 0; next state=RUN, wait_cnt=0. A branch or hazard pending during the miss is therefore applied on the exit cycle.
- ERR: all *_we=0 and all flush/bubble=0. Held until rst; mem_err stays 1.
- stall_cycles increments by 1 on every non-reset cycle with pc_we=0; saturates at all-ones, no wrap.
- Reset mid-DMISS returns to RUN immediately; the pending access is abandoned.

Decomposition:
- Package pipe_ctl_pkg: state encodings RUN/DMISS/ERR; REG_ZERO=5'd0.
- One sub-module, hazard_detect: purely combinational load-use compare, instantiated once.
- FSM, wait counter and perf counter stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles → all *_we=0, idex_bubble=1, stall_cycles=0, state=0. Release → all *_we=1.
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 for 1 cycle → pc_we=0, ifid_we=0, idex_bubble=1, idex_we=1, stall_cycles=1. Repeat with idex_rt=0 → no stall.
- Data miss: dmem_req=1, dmem_hit=0 for 3 cycles, then hit → 3 cycles of all *_we=0, state=1; hit cycle all *_we=1, state returns to 0, stall_cycles=3.
- Miss with branch: branch_taken=1 held during a 2-cycle miss → freeze for 2 cycles, then exit cycle shows ifid_flush=1, idex_bubble=1, exmem_flush=1.
- Timeout: MAX_WAIT=4, dmem_hit held 0 → state=2 and mem_err=1 after 3 DMISS cycles; outputs stay frozen until rst.
- Saturation and priority: CNT_W=4, 20 I-miss cycles → stall_cycles=15. branch_taken with load-use in the same cycle → pc_we=1 and flushes asserted.
